wb_data_ram: RTL
================

WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data bus width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the storage depth in XLEN-bit words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning the extra cycles inserted before ACK (0..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port mm_bus, wishbone.SLAVE, XLEN: responder end; uses ADR, DAT_W, DAT_R, WE, STB, SEL, ACK.
REQ-007 SHALL have port err_clr, input, 1 bit: synchronous clear of misalign_err.
REQ-008 SHALL have port misalign_err, output, 1 bit: sticky flag, set by any misaligned access.

Function
REQ-009 SHALL treat ADR as a byte address; word index = ADR[$clog2(DEPTH_WORDS)+1:2], upper bits ignored (wrap modulo DEPTH_WORDS*4).
REQ-010 SHALL interpret SEL as low-lane-justified size: 0001 byte, 0011 half, 1111 word; any other SEL is treated as word.
REQ-011 SHALL, on write, shift DAT_W and SEL left by 8*ADR[1:0] and update only the enabled byte lanes.
REQ-012 SHALL, on read, return the addressed word shifted right by 8*ADR[1:0] (low-justified), upper unselected bits zero.
REQ-013 SHALL classify an access as misaligned when half has ADR[0]=1 or word has ADR[1:0]!=0; misaligned: ACK given, no write, DAT_R=0, misalign_err set.
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE samples STB=1, latches ADR/DAT_W/SEL/WE, loads a counter with WAIT_STATES.
REQ-015 SHALL go from IDLE to RESP directly when WAIT_STATES=0; otherwise stay in WAIT until the counter reaches 0, decrementing once per cycle.
REQ-016 SHALL assert ACK only in RESP, for exactly one cycle; ACK is registered (no combinational path from STB to ACK).
REQ-017 SHALL yield latency from first STB-high edge to ACK-high of WAIT_STATES+1 cycles.
REQ-018 SHALL commit a write to storage only on the clock edge ending RESP.
REQ-019 SHALL hold DAT_R valid during RESP; outside RESP, DAT_R is 0.
REQ-020 SHALL, if STB drops during WAIT, abort to IDLE with no ACK and no write.
REQ-021 SHALL ignore STB in RESP; the next access is accepted no earlier than the cycle after RESP (one idle turnaround).
REQ-022 SHALL give err_clr priority over a simultaneous misalign set (clear wins).
REQ-023 SHALL ignore a later write to the same address when reading back inside RESP, since data was captured at the RESP entry edge.

Reset
REQ-024 SHALL, on rst_n low, force state to IDLE, counter to 0, ACK to 0, DAT_R to 0 and misalign_err to 0, asynchronously.
REQ-025 SHALL, on reset mid-transaction, perform no write and emit no ACK; storage contents are not reset.

Structure
REQ-026 SHALL place the SEL encodings (SEL_BYTE, SEL_HALF, SEL_WORD) and the FSM state enum in shared package mem_pkg.
REQ-027 SHALL implement storage in sub-module wb_ram_array: synchronous single-port, byte-enable write, registered read.

Verification
REQ-028 SHALL verify word write then read: write ADR=0x10, DAT_W=0xDEADBEEF, SEL=1111; then read 0x10 -> ACK 2 cycles after STB, DAT_R=0xDEADBEEF.
REQ-029 SHALL verify byte lane: write byte 0xAA at ADR=0x13 over word 0x11223344 -> word reads 0xAA223344; byte read at 0x13 -> DAT_R=0x000000AA.
REQ-030 SHALL verify misaligned: half write at ADR=0x21 -> ACK, memory unchanged, misalign_err=1; err_clr pulse -> 0.
REQ-031 SHALL verify abort: STB high 1 cycle with WAIT_STATES=3, then low -> no ACK, no write, FSM in IDLE.
REQ-032 SHALL verify wrap: DEPTH_WORDS=1024, write 0x5 at ADR=0x1000 -> read ADR=0x0 returns 0x5.
REQ-033 SHALL verify reset mid-WAIT: rst_n low during write -> ACK=0 immediately, target word unchanged after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the Wishbone data RAM: SEL size encodings, FSM states, size helpers.
// Latency: none (declarations only).
// Backpressure: none.
package mem_pkg;

   // SEL is low-lane justified and encodes the access size.
   localparam logic [3:0] SEL_BYTE = 4'b0001;
   localparam logic [3:0] SEL_HALF = 4'b0011;
   localparam logic [3:0] SEL_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   function automatic size_t decode_size(input logic [3:0] sel);
      size_t sz;
      case (sel)
         SEL_BYTE: sz = SZ_BYTE;
         SEL_HALF: sz = SZ_HALF;
         SEL_WORD: sz = SZ_WORD;
         default:  sz = SZ_WORD;   // unrecognised patterns fall back to a full word
      endcase
      return sz;
   endfunction

   function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
      logic mis;
      case (sz)
         SZ_HALF: mis = off[0];
         SZ_WORD: mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/wishbone.sv
// Wishbone bus bundle: single-beat classic cycle with byte-lane SEL.
// Latency: none (wires only).
// Backpressure: the responder holds the initiator via ACK.
interface wishbone #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0]   ADR;
   logic [XLEN-1:0]   DAT_W;
   logic [XLEN-1:0]   DAT_R;
   logic              WE;
   logic              STB;
   logic [XLEN/8-1:0] SEL;
   logic              ACK;

   modport SLAVE  (input ADR, DAT_W, WE, STB, SEL, output DAT_R, ACK);
   modport MASTER (output ADR, DAT_W, WE, STB, SEL, input DAT_R, ACK);
endinterface

// File: rtl/wb_ram_array.sv
// Word storage: synchronous single-port RAM with byte-enable write and registered read.
// Latency: read data appears one clock after re; writes land on the clock edge with we.
// Backpressure: none, accepts one operation per cycle.
// Ports: clk; addr word index; we/be/wdata write side; re/rdata read side.
module wb_ram_array #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic                           we,
   input  logic [XLEN/8-1:0]              be,
   input  logic [XLEN-1:0]                wdata,
   input  logic                           re,
   output logic [XLEN-1:0]                rdata
);
   logic [XLEN-1:0] mem [DEPTH_WORDS];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < XLEN/8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/wb_data_ram.sv
// Wishbone data RAM with byte/half/word access, misalignment detection and sticky error flag.
// Latency: ACK WAIT_STATES+1 cycles after STB is first sampled; one idle cycle after each ACK.
// Backpressure: initiator holds STB until ACK; dropping STB while waiting aborts the access.
// Ports: clk, rst_n (async active-low); mm_bus responder; err_clr clears misalign_err.
module wb_data_ram
   import mem_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   wishbone.SLAVE mm_bus,
   input  logic   err_clr,
   output logic   misalign_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int SW = XLEN/8;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            ack_q;
   logic            accept;
   size_t           bus_size;

   // Request fields captured when IDLE accepts STB.
   logic [AW-1:0]   idx_q;
   logic [1:0]      off_q;
   size_t           size_q;
   logic            we_q;
   logic            mis_q;
   logic [XLEN-1:0] dat_q;

   logic [AW-1:0]   arr_idx;
   logic            arr_we, arr_re;
   logic [SW-1:0]   lane_mask, arr_be;
   logic [XLEN-1:0] data_mask, arr_wdata, arr_rdata;
   logic            unused_adr;

   assign bus_size   = decode_size(mm_bus.SEL[3:0]);
   assign accept     = (state == ST_IDLE) && mm_bus.STB;
   assign unused_adr = ^mm_bus.ADR[XLEN-1:AW+2];   // upper address bits wrap away

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (mm_bus.STB) begin
               cnt_nxt   = 4'(WAIT_STATES);
               state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!mm_bus.STB) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               // Leave as the count reaches zero so WAIT lasts exactly WAIT_STATES cycles.
               cnt_nxt = cnt - 4'd1;
               if (cnt <= 4'd1) state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;   // STB ignored here: forced turnaround cycle
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         ack_q        <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack_q <= (state_nxt == ST_RESP);
         if (err_clr)
            misalign_err <= 1'b0;
         else if ((state == ST_RESP) && mis_q)
            misalign_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q  <= mm_bus.ADR[AW+1:2];
         off_q  <= mm_bus.ADR[1:0];
         size_q <= bus_size;
         we_q   <= mm_bus.WE;
         dat_q  <= mm_bus.DAT_W;
         mis_q  <= is_misaligned(bus_size, mm_bus.ADR[1:0]);
      end
   end

   always_comb begin
      lane_mask = '1;
      data_mask = '1;
      case (size_q)
         SZ_BYTE: begin lane_mask = SW'(1); data_mask = XLEN'(8'hFF);   end
         SZ_HALF: begin lane_mask = SW'(3); data_mask = XLEN'(16'hFFFF); end
         default: ;
      endcase
   end

   // With zero wait states RESP is entered on the accept edge, so the read
   // address must come straight from the bus while IDLE.
   assign arr_idx   = (state == ST_IDLE) ? mm_bus.ADR[AW+1:2] : idx_q;
   assign arr_re    = (state_nxt == ST_RESP);
   assign arr_we    = (state == ST_RESP) && we_q && !mis_q;
   assign arr_be    = lane_mask << off_q;
   assign arr_wdata = dat_q << {off_q, 3'b000};

   wb_ram_array #(
      .XLEN        (XLEN),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .addr  (arr_idx),
      .we    (arr_we),
      .be    (arr_be),
      .wdata (arr_wdata),
      .re    (arr_re),
      .rdata (arr_rdata)
   );

   assign mm_bus.ACK   = ack_q;
   assign mm_bus.DAT_R = ((state == ST_RESP) && !mis_q)
                         ? ((arr_rdata >> {off_q, 3'b000}) & data_mask) : '0;
endmodule
